// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative M-extension engine (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// A shift-add multiplier and a restoring divider share one 2*XLEN working register and
// run one iteration per cycle. Control is an IDLE/CALC/FIX/DONE FSM with a start/busy/done
// handshake.
// Optional build macro FAST_MUL_EN:
//   - When defined, the MUL* ops finish at accept using a combinational full product.
//   - When undefined, every op takes the iterative path.
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   start, kill   op request (taken in IDLE/DONE); flush that aborts any op
//   op            M-group function select (alufn[2:0])
//   rs1, rs2      operand a (dividend/multiplicand), operand b (divisor/multiplier)
//   busy          high in CALC and FIX
//   stall_o       holds the core: busy, or start that does not complete next cycle
//   done          one-cycle pulse, result valid
//   result        registered result, held until the next op completes
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            stall_o,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpRem    = 3'b110;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;     // mul: {hi, multiplier}; div: {rem, quotient}
  logic [XLEN-1:0]       opnd_q, opnd_d;   // mul: multiplicand; div: divisor
  logic [2:0]            op_q, op_d;
  logic                  neg_q, neg_d;     // negate product / quotient
  logic                  sign_a_q, sign_a_d;
  logic [XLEN-1:0]       result_q, result_d;

  // Accept-time operand conditioning
  logic            is_div, signed_a, signed_b, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div   = op[2];
    signed_a = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    signed_b = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    sa       = signed_a & rs1[XLEN-1];
    sb       = signed_b & rs2[XLEN-1];
    a_mag    = sa ? (~rs1 + 1'b1) : rs1;
    b_mag    = sb ? (~rs2 + 1'b1) : rs2;
  end

  logic div_zero, div_ovf;
  always_comb begin
    div_zero = is_div && (rs2 == '0);
    div_ovf  = ((op == OpDiv) || (op == OpRem)) &&
               (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] full_p, full_s;
  always_comb begin
    full_p = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    full_s = (sa ^ sb) ? (~full_p + 1'b1) : full_p;
    special     = is_div ? (div_zero || div_ovf) : 1'b1;
    special_res = '0;
    if (!is_div) begin
      special_res = (op == OpMul) ? full_s[XLEN-1:0] : full_s[2*XLEN-1:XLEN];
    end else if (div_zero) begin
      special_res = op[1] ? rs1 : '1;
    end else begin
      special_res = op[1] ? '0 : rs1;
    end
  end
`else
  always_comb begin
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? rs1 : '1;
    end else begin
      special_res = op[1] ? '0 : rs1;
    end
  end
`endif

  // One iteration of each algorithm
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step;
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    // Borrow out of the subtraction means the trial quotient bit is 0: restore.
    if (!div_diff[XLEN]) begin
      div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and word select
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot, rem, fix_res;
  always_comb begin
    prod_s = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot   = acc_q[XLEN-1:0];
    rem    = acc_q[2*XLEN-1:XLEN];
    if (!op_q[2]) begin
      fix_res = (op_q == OpMul) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (!op_q[1]) begin
      fix_res = neg_q ? (~quot + 1'b1) : quot;
    end else begin
      fix_res = sign_a_q ? (~rem + 1'b1) : rem;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    result_d = result_q;
    if (kill) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          if (start) begin
            op_d     = op;
            neg_d    = sa ^ sb;
            sign_a_d = sa;
            if (special) begin
              state_d  = StDone;
              result_d = special_res;
            end else begin
              state_d = StCalc;
              cnt_d   = CntW'(XLEN - 1);
              acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              opnd_d  = is_div ? b_mag : a_mag;
            end
          end
        end
        StCalc: begin
          acc_d = op_q[2] ? div_step : mul_step;
          if (cnt_q == '0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StFix: begin
          result_d = fix_res;
          state_d  = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    busy    = (state_q == StCalc) || (state_q == StFix);
    done    = (state_q == StDone);
    stall_o = busy || (start && (state_d != StDone));
    result  = result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, stall_o, done;
  logic [31:0] result;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] last_res = '0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .kill    (kill),
    .op      (op),
    .rs1     (rs1),
    .rs2     (rs2),
    .busy    (busy),
    .stall_o (stall_o),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int qa, qb;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    qa = a;
    qb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(qa / qb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(qa % qb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 34;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int cycles;
    int exp_lat;
    logic [31:0] exp_res;
    exp_lat = ref_lat(f, a, b);
    exp_res = ref_result(f, a, b);
    @(negedge clk);
    start = 1'b1;
    op = f;
    rs1 = a;
    rs2 = b;
    #1;
    check_eq("stall_at_start", 32'(stall_o), 32'(exp_lat != 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operands must already be captured
    rs1 = $urandom;
    rs2 = $urandom;
    op = 3'($urandom);
    cycles = 1;
    check_eq("busy_after_accept", 32'(busy), 32'(exp_lat != 1));
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq("latency", 32'(cycles), 32'(exp_lat));
    check_eq("result", result, exp_res);
    last_res = exp_res;
  endtask

  task automatic no_done_for(input int n, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check_eq(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0] f;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_stall", 32'(stall_o), 32'd0);

    // Directed cases
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd4, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    // Back-to-back: each call starts while the previous DONE is showing
    run_op(3'd5, 32'd9, 32'd0);
    run_op(3'd4, 32'd9, 32'd0);

    // Kill during CALC
    run_op(3'd5, 32'd77, 32'd5);
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check_eq("kill_busy", 32'(busy), 32'd0);
    check_eq("kill_done", 32'(done), 32'd0);
    no_done_for(40, "kill_no_done");
    check_eq("kill_result_held", result, last_res);

    // Kill and start together
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 3'd5; rs1 = 32'd50; rs2 = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    check_eq("startkill_busy", 32'(busy), 32'd0);
    check_eq("startkill_done", 32'(done), 32'd0);
    no_done_for(5, "startkill_no_done");
    check_eq("startkill_result", result, last_res);

    // Randomized ops
    for (int i = 0; i < 120; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
        3: begin a = -$urandom_range(0, 255); b = -$urandom_range(1, 15); end
        default: ;
      endcase
      run_op(f, a, b);
    end

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done_for(40, "arst_no_done");
    run_op(3'd7, 32'd100, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
